// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the wait-state RAM FSM state type.
// No logic; constants and types only.
// Imported by the RAM top and the byte-lane decoder.
package ahb_lite_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings supported by the RAM
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // RAM slave FSM: idle/final data phase, stall, two-cycle error response
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ram_state_t;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Byte-lane enables and alignment check for an AHB-Lite address phase.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is sampled.
module ahb_byte_lane_decode
    import ahb_lite_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] haddr_i,
    output logic [3:0] byte_select_o,
    output logic       align_err_o
);

    // Lane select by size/offset; sizes above a word select nothing and flag an error
    always_comb begin
        byte_select_o = 4'b0000;
        align_err_o   = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: begin
                byte_select_o = 4'b0001 << haddr_i;
            end
            HSIZE_HALF: begin
                byte_select_o = haddr_i[1] ? 4'b1100 : 4'b0011;
                align_err_o   = haddr_i[0];
            end
            HSIZE_WORD: begin
                byte_select_o = 4'b1111;
                align_err_o   = |haddr_i;
            end
            default: begin
                align_err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_ram_ws.sv
// AHB-Lite RAM slave with WAIT_STATES stall cycles per transfer and ERROR on bad size/alignment.
// Latency: OKAY data phase = WAIT_STATES+1 cycles; ERROR data phase = 2 cycles.
// Backpressure: HREADYOUT low while stalling or in the first error cycle; next address accepted on the final cycle.
module ahb_ram_ws
    import ahb_lite_pkg::*;
#(
    parameter int    MEMWIDTH    = 8,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int WORDS = 2 ** (MEMWIDTH - 2);
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int AW    = MEMWIDTH - 2;

    logic [31:0] mem [WORDS];

    ram_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dphase_q, dphase_d;  // an OKAY data phase is in flight
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    bsel_q, bsel_d;

    logic [3:0]    dec_bsel;
    logic          dec_err;
    logic          accept;
    logic          final_phase;
    logic          mem_we;
    logic [31:0]   lane_mask;

    // Upper address bits alias by design; HTRANS[0] only distinguishes NONSEQ/SEQ
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:MEMWIDTH], HTRANS[0]};

    ahb_byte_lane_decode u_lane_dec (
        .hsize_i       (HSIZE),
        .haddr_i       (HADDR[1:0]),
        .byte_select_o (dec_bsel),
        .align_err_o   (dec_err)
    );

    // New address phases are only taken when this slave is showing HREADYOUT=1
    assign accept = HREADY & HSEL & HTRANS[1] &
                    ((state_q == ST_IDLE) | (state_q == ST_ERR2));

    // IDLE with an armed data phase is the single completing cycle of an OKAY transfer
    assign final_phase = (state_q == ST_IDLE) & dphase_q;
    assign mem_we      = final_phase & write_q;

    assign lane_mask = {{8{bsel_q[3]}}, {8{bsel_q[2]}}, {8{bsel_q[1]}}, {8{bsel_q[0]}}};

    assign HREADYOUT = (state_q != ST_WAIT) & (state_q != ST_ERR1);
    assign HRESP     = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (final_phase & ~write_q) ? (mem[addr_q] & lane_mask) : 32'h0;

    // Next-state: accept/latch control, run the stall counter, sequence the error response
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = dphase_q;
        write_d  = write_q;
        addr_d   = addr_q;
        bsel_d   = bsel_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d  = ST_IDLE;
                dphase_d = 1'b0;
                if (accept) begin
                    write_d = HWRITE;
                    addr_d  = HADDR[MEMWIDTH-1:2];
                    bsel_d  = dec_bsel;
                    if (dec_err) begin
                        // errored transfers never arm a data phase, so they cannot write
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d  = ST_WAIT;
                        cnt_d    = CW'(WAIT_STATES);
                        dphase_d = 1'b1;
                    end else begin
                        dphase_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d  = ST_IDLE;
                dphase_d = 1'b0;
            end
        endcase
    end

    // Control registers; reset abandons any in-flight transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dphase_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            bsel_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            bsel_q   <= bsel_d;
        end
    end

    // Per-lane write on the closing edge of the final write data-phase cycle
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bsel_q[i]) begin
                    mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_ram_ws.sv
// Directed bench for ahb_ram_ws at WAIT_STATES=0 (dut 0) and WAIT_STATES=3 (dut 1).
// Each DUT is the only slave on its own bus, so HREADY is its own HREADYOUT.
// Inputs driven and outputs sampled 1 time unit after the rising clock edge.
module tb_ahb_ram_ws;
    import ahb_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n  [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic [31:0] hrdata [2];

    int ws [2] = '{0, 3};
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ahb_ram_ws #(.MEMWIDTH(8), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HREADY(hready[0]),
        .HADDR(haddr[0]), .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
        .HWDATA(hwdata[0]), .HREADYOUT(hready[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
    );

    ahb_ram_ws #(.MEMWIDTH(8), .WAIT_STATES(3), .INIT_FILE("")) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HREADY(hready[1]),
        .HADDR(haddr[1]), .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
        .HWDATA(hwdata[1]), .HREADYOUT(hready[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
    );

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    // One non-pipelined transfer; returns after sampling its final data-phase cycle
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int stall,
                        output logic resp_first, output logic resp_last, output logic dirty);
        @(posedge clk); #1;
        hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; haddr[d] = addr; hwrite[d] = wr; hsize[d] = size;
        @(posedge clk); #1;
        htrans[d] = HTRANS_IDLE; hwdata[d] = wdata;
        stall = 0; dirty = 1'b0; resp_first = hresp[d];
        while (hready[d] !== 1'b1 && stall < 40) begin
            if (hrdata[d] !== 32'h0) dirty = 1'b1;
            stall++;
            @(posedge clk); #1;
        end
        rdata = hrdata[d]; resp_last = hresp[d];
    endtask

    task automatic wr_ok(input int d, input string tag, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
        logic [31:0] r; int s; logic rf, rl, dy;
        xfer(d, 1'b1, addr, size, data, r, s, rf, rl, dy);
        chk(d, {tag, "_stall"}, s, ws[d]);
        chk(d, {tag, "_resp"}, {31'h0, rf | rl}, 32'h0);
    endtask

    task automatic rd_ok(input int d, input string tag, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
        logic [31:0] r; int s; logic rf, rl, dy;
        xfer(d, 1'b0, addr, size, 32'h0, r, s, rf, rl, dy);
        chk(d, {tag, "_data"}, r, exp);
        chk(d, {tag, "_stall"}, s, ws[d]);
        chk(d, {tag, "_resp_zero_in_wait"}, {30'h0, rl, dy}, 32'h0);
    endtask

    task automatic xfer_err(input int d, input string tag, input logic wr, input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] r; int s; logic rf, rl, dy;
        xfer(d, wr, addr, size, 32'hFFFF_FFFF, r, s, rf, rl, dy);
        chk(d, {tag, "_err1_resp"}, {31'h0, rf}, 32'h1);
        chk(d, {tag, "_err_len"}, s, 1);
        chk(d, {tag, "_err2_resp"}, {31'h0, rl}, 32'h1);
        chk(d, {tag, "_rdata"}, r, 32'h0);
        chk(d, {tag, "_rdata_err1"}, {31'h0, dy}, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = HTRANS_IDLE;
            hwrite[d] = 1'b0; hsize[d] = HSIZE_WORD; hwdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(d, "reset_outputs", {hready[d], hresp[d], hrdata[d][29:0]}, {1'b1, 1'b0, 30'h0});
            chk(d, "reset_rdata", hrdata[d], 32'h0);
        end
        #3;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        for (int d = 0; d < 2; d++) begin
            // T1 word write then read
            wr_ok(d, "t1_wr", 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
            rd_ok(d, "t1_rd", 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);

            // T2 byte and halfword merges over a known word
            wr_ok(d, "t2_wr_word", 32'h10, HSIZE_WORD, 32'h1122_3344);
            wr_ok(d, "t2_wr_byte", 32'h13, HSIZE_BYTE, 32'hAA00_0000);
            wr_ok(d, "t2_wr_half", 32'h10, HSIZE_HALF, 32'h0000_5566);
            rd_ok(d, "t2_rd_word", 32'h10, HSIZE_WORD, 32'hAA22_5566);
            rd_ok(d, "t2_rd_byte", 32'h13, HSIZE_BYTE, 32'hAA00_0000);

            // T3 misaligned word write errors and leaves memory alone
            xfer_err(d, "t3_misaligned_wr", 1'b1, 32'h12, HSIZE_WORD);
            rd_ok(d, "t3_rd_after", 32'h10, HSIZE_WORD, 32'hAA22_5566);

            // T4 unsupported size and misaligned halfword reads
            xfer_err(d, "t4_size3_rd", 1'b0, 32'h10, 3'd3);
            xfer_err(d, "t4_half_odd_rd", 1'b0, 32'h01, HSIZE_HALF);

            // T5 back-to-back write then read of the same word
            @(posedge clk); #1;
            hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; haddr[d] = 32'h20; hwrite[d] = 1'b1; hsize[d] = HSIZE_WORD;
            @(posedge clk); #1;
            hwdata[d] = 32'h0102_0304; hwrite[d] = 1'b0;
            n = 0;
            while (hready[d] !== 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
            chk(d, "t5_wr_stall", n, ws[d]);
            @(posedge clk); #1;
            htrans[d] = HTRANS_IDLE;
            n = 0;
            while (hready[d] !== 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
            chk(d, "t5_rd_stall", n, ws[d]);
            chk(d, "t5_rd_data", hrdata[d], 32'h0102_0304);
            chk(d, "t5_rd_resp", {31'h0, hresp[d]}, 32'h0);

            // IDLE and BUSY transfers: no stall, OKAY, no write
            @(posedge clk); #1;
            hsel[d] = 1'b1; htrans[d] = HTRANS_IDLE; haddr[d] = 32'h10; hwrite[d] = 1'b1; hsize[d] = HSIZE_WORD;
            @(posedge clk); #1;
            hwdata[d] = 32'h0; htrans[d] = HTRANS_BUSY;
            chk(d, "idle_no_stall", {30'h0, hready[d], hresp[d]}, 32'h2);
            @(posedge clk); #1;
            htrans[d] = HTRANS_IDLE;
            chk(d, "busy_no_stall", {30'h0, hready[d], hresp[d]}, 32'h2);
            chk(d, "busy_rdata", hrdata[d], 32'h0);
            rd_ok(d, "idle_busy_no_write", 32'h10, HSIZE_WORD, 32'hAA22_5566);
        end

        // T6 reset in the middle of a stalled write (WAIT_STATES=3)
        wr_ok(1, "t6_pre_wr", 32'h30, HSIZE_WORD, 32'h1111_1111);
        @(posedge clk); #1;
        hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD;
        @(posedge clk); #1;
        htrans[1] = HTRANS_IDLE; hwdata[1] = 32'h9999_9999;
        chk(1, "t6_in_wait", {31'h0, hready[1]}, 32'h0);
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        #1;
        chk(1, "t6_rst_outputs", {30'h0, hready[1], hresp[1]}, 32'h2);
        chk(1, "t6_rst_rdata", hrdata[1], 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n[1] = 1'b1;
        rd_ok(1, "t6_rd_after_rst", 32'h30, HSIZE_WORD, 32'h1111_1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
